// File: rtl/sad_search_ctrl.sv
// Motion-search sequencer: walks a (2*RANGE+1)^2 candidate window in raster order and
// tracks the lowest SAD returned by a LAT-cycle pipelined adder tree.
module sad_search_ctrl #(
    parameter int RANGE = 4,
    parameter int LAT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               fetch_rdy,
    input  logic [13:0]        sad_in,
    output logic               cand_valid,
    output logic signed [3:0]  cand_dx,
    output logic signed [3:0]  cand_dy,
    output logic               busy,
    output logic               done,
    output logic [13:0]        min_sad,
    output logic signed [3:0]  mv_x,
    output logic signed [3:0]  mv_y
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic signed [3:0] OFS_MIN = 4'(-RANGE);
    localparam logic signed [3:0] OFS_MAX = 4'(RANGE);

    state_t             state;
    logic [LAT-1:0]     vld_sr;
    logic signed [3:0]  dx_dl [LAT];
    logic signed [3:0]  dy_dl [LAT];
    logic [13:0]        best_sad;
    logic signed [3:0]  best_x;
    logic signed [3:0]  best_y;
    logic               have_best;
    logic               last_issue;
    logic               ret_vld;
    logic               take;
    logic               drained;

    assign cand_valid = (state == ISSUE) && fetch_rdy;
    assign last_issue = cand_valid && (cand_dx == OFS_MAX) && (cand_dy == OFS_MAX);
    assign ret_vld    = vld_sr[LAT-1];
    assign drained    = (vld_sr == '0);
    // First return of a search is taken unconditionally; later ones only on a strict improvement
    assign take       = ret_vld && (!have_best || (sad_in < best_sad));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (last_issue) state <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Raster walk: dx inner, dy outer; advances only on an accepted issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_dx <= OFS_MIN;
            cand_dy <= OFS_MIN;
        end else if (state == IDLE && start) begin
            cand_dx <= OFS_MIN;
            cand_dy <= OFS_MIN;
        end else if (cand_valid) begin
            if (last_issue) begin
                cand_dx <= OFS_MIN;
                cand_dy <= OFS_MIN;
            end else if (cand_dx == OFS_MAX) begin
                cand_dx <= OFS_MIN;
                cand_dy <= cand_dy + 4'sd1;
            end else begin
                cand_dx <= cand_dx + 4'sd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= cand_valid;
            for (int i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    // Offset delay line mirrors the adder-tree latency; only qualified by vld_sr
    always_ff @(posedge clk) begin
        dx_dl[0] <= cand_dx;
        dy_dl[0] <= cand_dy;
        for (int i = 1; i < LAT; i++) begin
            dx_dl[i] <= dx_dl[i-1];
            dy_dl[i] <= dy_dl[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_best <= 1'b0;
            best_sad  <= '0;
            best_x    <= '0;
            best_y    <= '0;
            min_sad   <= '0;
            mv_x      <= '0;
            mv_y      <= '0;
        end else begin
            if (state == IDLE && start) begin
                have_best <= 1'b0;
                best_sad  <= '0;
                best_x    <= '0;
                best_y    <= '0;
            end else if (take) begin
                have_best <= 1'b1;
                best_sad  <= sad_in;
                best_x    <= dx_dl[LAT-1];
                best_y    <= dy_dl[LAT-1];
            end
            if (state == DRAIN && drained) begin
                min_sad <= best_sad;
                mv_x    <= best_x;
                mv_y    <= best_y;
            end
        end
    end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Randomized/directed bench for sad_search_ctrl: an adder-tree stand-in answers each issued
// candidate LAT cycles later from a SAD table; results are compared to a raster-scan minimum.
module tb_sad_search_ctrl;

    localparam int R_A = 4;
    localparam int L_A = 4;
    localparam int N_A = (2*R_A+1)*(2*R_A+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic              start_a = 1'b0, fetch_a = 1'b0;
    logic [13:0]       sad_a;
    logic              cand_valid_a, busy_a, done_a;
    logic signed [3:0] cand_dx_a, cand_dy_a, mv_x_a, mv_y_a;
    logic [13:0]       min_sad_a;

    logic              start_b = 1'b0, fetch_b = 1'b0;
    logic [13:0]       sad_b = 14'h3FFF;
    logic              cand_valid_b, busy_b, done_b;
    logic signed [3:0] cand_dx_b, cand_dy_b, mv_x_b, mv_y_b;
    logic [13:0]       min_sad_b;

    sad_search_ctrl #(.RANGE(R_A), .LAT(L_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .fetch_rdy(fetch_a), .sad_in(sad_a),
        .cand_valid(cand_valid_a), .cand_dx(cand_dx_a), .cand_dy(cand_dy_a),
        .busy(busy_a), .done(done_a), .min_sad(min_sad_a), .mv_x(mv_x_a), .mv_y(mv_y_a));

    sad_search_ctrl #(.RANGE(1), .LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .fetch_rdy(fetch_b), .sad_in(sad_b),
        .cand_valid(cand_valid_b), .cand_dx(cand_dx_b), .cand_dy(cand_dy_b),
        .busy(busy_b), .done(done_b), .min_sad(min_sad_b), .mv_x(mv_x_b), .mv_y(mv_y_b));

    int total = 0;
    int bad   = 0;

    logic [13:0] sadv [N_A];
    int exp_idx   = 0;
    int issue_cnt = 0;
    int done_cnt  = 0;
    int cyc       = 0;
    bit hv  [64];
    int hdx [64];
    int hdy [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Adder-tree stand-in: the SAD of the candidate seen in cycle c is presented in cycle c+LAT;
    // cycles with nothing returning carry random garbage.
    initial begin
        sad_a = '0;
        for (int i = 0; i < 64; i++) hv[i] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= L_A && hv[(cyc-L_A)%64])
                sad_a = sadv[(hdy[(cyc-L_A)%64] + R_A)*(2*R_A+1) + hdx[(cyc-L_A)%64] + R_A];
            else
                sad_a = 14'($urandom);
            @(negedge clk);
            hv[cyc%64]  = cand_valid_a;
            hdx[cyc%64] = int'(cand_dx_a);
            hdy[cyc%64] = int'(cand_dy_a);
            if (cand_valid_a) begin
                check("raster_order", {24'd0, cand_dy_a, cand_dx_a},
                      {24'd0, 4'(exp_idx/(2*R_A+1) - R_A), 4'(exp_idx%(2*R_A+1) - R_A)});
                exp_idx++;
                issue_cnt++;
            end
            if (done_a) done_cnt++;
        end
    end

    // Reference: scan the window in raster order, keep the first strict minimum.
    task automatic model(output logic [13:0] ms, output logic signed [3:0] mx,
                         output logic signed [3:0] my);
        int bi;
        bi = 0;
        for (int i = 1; i < N_A; i++) if (sadv[i] < sadv[bi]) bi = i;
        ms = sadv[bi];
        mx = 4'(bi%(2*R_A+1) - R_A);
        my = 4'(bi/(2*R_A+1) - R_A);
    endtask

    task automatic fill(input int lo, input int hi);
        for (int i = 0; i < N_A; i++) sadv[i] = 14'($urandom_range(hi, lo));
    endtask

    function automatic int idx_of(input int dx, input int dy);
        return (dy + R_A)*(2*R_A+1) + dx + R_A;
    endfunction

    task automatic run_search(input string tag, input bit toggle, input int restart_at);
        logic [13:0]       ems;
        logic signed [3:0] emx, emy;
        int  n;
        bit  seen;
        model(ems, emx, emy);
        @(posedge clk); #1;
        exp_idx = 0; issue_cnt = 0; done_cnt = 0;
        start_a = 1'b1; fetch_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 400) begin
            if (toggle) fetch_a = ~fetch_a;
            start_a = (n == restart_at);
            @(negedge clk);
            if (done_a) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        start_a = 1'b0; fetch_a = 1'b1;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (!toggle) check({tag, "_latency"}, n, N_A + L_A + 1);
        check({tag, "_issues"}, issue_cnt, N_A);
        check({tag, "_min_sad"}, 32'(min_sad_a), 32'(ems));
        check({tag, "_mv_x"}, mv_x_a, emx);
        check({tag, "_mv_y"}, mv_y_a, emy);
        check({tag, "_busy_in_done"}, 32'(busy_a), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done_a), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_min_hold"}, 32'(min_sad_a), 32'(ems));
    endtask

    initial begin
        int n;
        int iss;
        bit seen;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_cand_valid", 32'(cand_valid_a), 32'd0);
        check("rst_cand_dx", cand_dx_a, 4'(-R_A));
        check("rst_cand_dy", cand_dy_a, 4'(-R_A));
        check("rst_min_sad", 32'(min_sad_a), 32'd0);
        check("rst_mv", {24'd0, mv_y_a, mv_x_a}, 32'd0);
        check("rst_b_cand_dx", cand_dx_b, 4'(-1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single minimum at (+2,-1)
        for (int i = 0; i < N_A; i++) sadv[i] = 14'd100;
        sadv[idx_of(2, -1)] = 14'd20;
        run_search("single_min", 1'b0, -1);
        check("single_min_value", 32'(min_sad_a), 32'd20);
        check("single_min_xy", {24'd0, mv_y_a, mv_x_a}, {24'd0, 4'hF, 4'h2});

        // Same table with fetch_rdy toggling every cycle
        run_search("toggle", 1'b1, -1);

        // Tie: earlier raster position wins
        for (int i = 0; i < N_A; i++) sadv[i] = 14'd50;
        sadv[idx_of(-3, 0)] = 14'd5;
        sadv[idx_of(1, 2)]  = 14'd5;
        run_search("tie", 1'b0, -1);
        check("tie_xy", {24'd0, mv_y_a, mv_x_a}, {24'd0, 4'h0, 4'hD});

        // Random tables, including a second start during ISSUE and dense ties
        fill(0, 16383);
        run_search("rand_restart", 1'b0, 10);
        fill(0, 7);
        run_search("rand_ties_toggle", 1'b1, -1);
        fill(8000, 16383);
        run_search("rand_high", 1'b0, 30);

        // Abort at the 40th issue, then a clean search
        fill(0, 16383);
        @(posedge clk); #1;
        exp_idx = 0; issue_cnt = 0; done_cnt = 0;
        start_a = 1'b1; fetch_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (issue_cnt < 40 && n < 400) begin
            @(negedge clk); #2;
            n++;
        end
        check("abort_reached_40", issue_cnt, 40);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_cand_valid", 32'(cand_valid_a), 32'd0);
        check("abort_cand_xy", {24'd0, cand_dy_a, cand_dx_a}, {24'd0, 4'(-R_A), 4'(-R_A)});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        run_search("after_abort", 1'b0, -1);

        // Small window, LAT=2, all SADs saturated
        @(posedge clk); #1;
        start_b = 1'b1; fetch_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0; iss = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (cand_valid_b) iss++;
            if (done_b) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("small_done_seen", 32'(seen), 32'd1);
        check("small_latency", n, 12);
        check("small_issues", iss, 9);
        check("small_min_sad", 32'(min_sad_b), 32'd16383);
        check("small_mv", {24'd0, mv_y_b, mv_x_b}, {24'd0, 4'hF, 4'hF});
        check("small_busy", 32'(busy_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 SHALL have parameter RANGE, default 4: search window is dx,dy in [-RANGE,+RANGE]; legal values 1..7.
REQ-002 SHALL have parameter LAT, default 4: cycles from a candidate issue to its SAD on sad_in; legal values 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a search; honoured only in IDLE.
REQ-006 SHALL have port fetch_rdy, input, 1: pixel fetch can accept a candidate this cycle.
REQ-007 SHALL have port sad_in, input, 14: SAD from the 64-pixel pipelined adder tree.
REQ-008 SHALL have port cand_valid, output, 1: candidate issued this cycle.
REQ-009 SHALL have port cand_dx and port cand_dy, output, 4 each, two's complement: candidate offset.
REQ-010 SHALL have port busy, output, 1: high in ISSUE and DRAIN.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when the result is final.
REQ-012 SHALL have port min_sad, output, 14: best SAD of the last completed search.
REQ-013 SHALL have port mv_x and port mv_y, output, 4 each, two's complement: offset of min_sad.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on start=1.
- ISSUE -> DRAIN on the cycle the last candidate issues.
- DRAIN -> DONE when no issued candidate is still in flight.
- DONE -> IDLE unconditionally.
REQ-015 SHALL drive cand_valid combinationally as (state==ISSUE && fetch_rdy); cand_dx/cand_dy come from registers and are meaningful only while cand_valid=1.
REQ-016 SHALL issue candidates in raster order, dy outer and dx inner, from (-RANGE,-RANGE) to (+RANGE,+RANGE), (2*RANGE+1)^2 in total (81 at default).
REQ-017 SHALL advance the offset only on cycles with cand_valid=1.
- fetch_rdy=0 in ISSUE holds the current offset and inserts a bubble.
- In-flight candidates keep advancing regardless of fetch_rdy.
REQ-018 SHALL track in-flight candidates with a LAT-deep valid shift register plus a LAT-deep dx/dy delay line; sad_in is sampled exactly LAT cycles after the matching cand_valid.
REQ-019 SHALL set the best value to the first returned SAD of a search unconditionally, with no sentinel compare.
REQ-020 SHALL replace the best value on each later returned SAD only if sad_in < best (unsigned, strict), so ties keep the earlier candidate in raster order.
REQ-021 SHALL keep the working best in internal registers and copy it to min_sad/mv_x/mv_y at the DRAIN->DONE edge; outputs SHALL then hold until the next search's DONE.
REQ-022 SHALL assert done for exactly the one cycle spent in DONE; busy SHALL be 0 in IDLE and DONE.
REQ-023 SHALL ignore start in ISSUE, DRAIN and DONE, with no queuing.
REQ-024 SHALL, when start arrives in IDLE, clear the working best and the offset counters; the in-flight shift register is already empty at that point.
REQ-025 SHALL ignore sad_in on cycles with no in-flight valid bit set.
REQ-026 SHALL, with fetch_rdy held at 1, assert done exactly (2*RANGE+1)^2 + LAT + 1 cycles after the start edge.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously set: state to IDLE; cand_valid, busy and done to 0; cand_dx/cand_dy to -RANGE; min_sad to 0; mv_x/mv_y to 0; the in-flight shift register to all-zero; the working best to 0.
REQ-028 SHALL, on reset mid-search, abandon the search with no done pulse; samples already inside the adder tree SHALL be discarded.

Verification
REQ-029 Start, fetch_rdy=1, sad_in = 100 everywhere except 20 at (+2,-1) -> done at start+86; min_sad=20; mv_x=2; mv_y=-1.
REQ-030 Tie: sad_in=5 at both (-3,0) and (+1,+2), 50 elsewhere -> mv_x=-3, mv_y=0; min_sad=5.
REQ-031 fetch_rdy toggled 1/0 every cycle -> 81 cand_valid pulses in raster order; no offset skipped or repeated; result matches the fetch_rdy=1 run.
REQ-032 Second start pulse during ISSUE -> ignored; exactly one done; candidate count stays 81.
REQ-033 rst_n low at the 40th issue, then start again -> no done for the aborted search; new search restarts at (-4,-4); correct result.
REQ-034 RANGE=1, LAT=2, all SAD = 14'h3FFF -> 9 issues; done at start+12; min_sad=16383; mv=(-1,-1).
